// File: rtl/up_tpl_profile_regs.sv
// Multi-profile JESD TPL register bank: profile select/status, per-profile descriptors,
// and the datapath profile-switch handshake. Optional macro: JESD_TPL_SWITCH_TIMEOUT_EN.
module up_tpl_profile_regs #(
    parameter int NUM_PROFILES    = 4,
    parameter int SEL_W           = 4,
    parameter int DEFAULT_PROFILE = 0,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                       up_clk,
    input  logic                       up_rstn,
    input  logic                       up_wreq,
    input  logic [13:0]                up_waddr,
    input  logic [31:0]                up_wdata,
    output logic                       up_wack,
    input  logic                       up_rreq,
    input  logic [13:0]                up_raddr,
    output logic [31:0]                up_rdata,
    output logic                       up_rack,
    input  logic [NUM_PROFILES*48-1:0] profile_desc,
    output logic [SEL_W-1:0]           profile_sel,
    output logic [SEL_W-1:0]           profile_next,
    output logic                       profile_req,
    input  logic                       profile_ack
);

    localparam logic [SEL_W-1:0] DEF_SEL = SEL_W'(DEFAULT_PROFILE);

    typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;
    state_t state, state_nxt;

    logic             wr_hit, rd_hit, wr_cntrl, wr_status;
    logic [SEL_W-1:0] wsel, cntrl_sel;
    logic             sel_invalid, busy, collision_ev, accept, start, ack_ev, timeout_ev;
    logic             st_invalid, st_collision, st_timeout;
    logic [31:0]      rd_val, status, sel_ext;
    logic [6:0]       rd_off, rd_poff;
    logic [3:0]       rd_p;
    logic [47:0]      rd_desc;

    assign wr_hit    = up_wreq && (up_waddr[13:7] == 7'h01);
    assign rd_hit    = up_rreq && (up_raddr[13:7] == 7'h01);
    assign wr_cntrl  = wr_hit && (up_waddr[6:0] == 7'h00);
    assign wr_status = wr_hit && (up_waddr[6:0] == 7'h01);
    assign wsel      = up_wdata[SEL_W-1:0];

    // Range check precedes the busy check, so an invalid value never counts as a collision
    assign sel_invalid  = wr_cntrl && ({{(32-SEL_W){1'b0}}, wsel} >= 32'(NUM_PROFILES));
    assign busy         = (state != IDLE);
    assign collision_ev = wr_cntrl && !sel_invalid && busy;
    assign accept       = wr_cntrl && !sel_invalid && !busy;
    assign start        = accept && (wsel != profile_sel);
    assign ack_ev       = (state == REQ) && profile_ack;
    assign profile_req  = (state == REQ);

`ifdef JESD_TPL_SWITCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt;

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn)
            to_cnt <= '0;
        else if (start)
            to_cnt <= '0;
        else if (state == REQ && !profile_ack)
            to_cnt <= to_cnt + 1'b1;
    end

    // Fires on the TIMEOUT_CYCLES-th cycle of REQ, so req is high for exactly that many cycles
    assign timeout_ev = (state == REQ) && !profile_ack && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_ev = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = REQ;
            REQ:     if (profile_ack || timeout_ev) state_nxt = RELEASE;
            RELEASE: if (!profile_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            profile_sel  <= DEF_SEL;
            profile_next <= DEF_SEL;
            cntrl_sel    <= DEF_SEL;
        end else begin
            if (ack_ev)
                profile_sel <= profile_next;
            if (start)
                profile_next <= wsel;
            else if (timeout_ev)
                profile_next <= profile_sel;
            if (accept)
                cntrl_sel <= wsel;
            else if (timeout_ev)
                cntrl_sel <= profile_sel;
        end
    end

    // Sticky status: set events override a same-cycle W1C
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            st_invalid   <= 1'b0;
            st_collision <= 1'b0;
            st_timeout   <= 1'b0;
        end else begin
            st_invalid   <= (st_invalid   & ~(wr_status & up_wdata[17])) | sel_invalid;
            st_collision <= (st_collision & ~(wr_status & up_wdata[18])) | collision_ev;
            st_timeout   <= (st_timeout   & ~(wr_status & up_wdata[19])) | timeout_ev;
        end
    end

    assign sel_ext = 32'(profile_sel);
    assign status  = {12'h0, st_timeout, st_collision, st_invalid, busy,
                      4'h0, sel_ext[3:0], 4'h0, 4'(NUM_PROFILES - 1)};

    assign rd_off  = up_raddr[6:0];
    assign rd_poff = rd_off - 7'h10;
    assign rd_p    = rd_poff[5:2];

    always_comb begin
        rd_desc = '0;
        for (int i = 0; i < NUM_PROFILES; i++)
            if (rd_p == 4'(i))
                rd_desc = profile_desc[48*i +: 48];
    end

    always_comb begin
        rd_val = '0;
        if (rd_off == 7'h00)
            rd_val[SEL_W-1:0] = cntrl_sel;
        else if (rd_off == 7'h01)
            rd_val = status;
        else if (rd_off >= 7'h10 && rd_off < 7'h50) begin
            if (rd_poff[1:0] == 2'd0)
                rd_val = rd_desc[31:0];
            else if (rd_poff[1:0] == 2'd1)
                rd_val = {16'h0, rd_desc[47:32]};
        end
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            up_wack  <= 1'b0;
            up_rack  <= 1'b0;
            up_rdata <= '0;
        end else begin
            up_wack  <= wr_hit;
            up_rack  <= rd_hit;
            up_rdata <= rd_hit ? rd_val : 32'h0;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{up_wdata, sel_ext, rd_poff[6]};

endmodule

// File: tb/tb_up_tpl_profile_regs.sv
// Randomized self-checking bench for up_tpl_profile_regs against a transaction-level model.
module tb_up_tpl_profile_regs;

    localparam int NPROF = 4;
    localparam int SW    = 4;
    localparam int TOC   = 16;

    logic             up_clk = 1'b0;
    logic             up_rstn = 1'b0;
    logic             up_wreq = 1'b0, up_rreq = 1'b0;
    logic [13:0]      up_waddr = '0, up_raddr = '0;
    logic [31:0]      up_wdata = '0;
    logic             up_wack, up_rack;
    logic [31:0]      up_rdata;
    logic [NPROF*48-1:0] profile_desc;
    logic [SW-1:0]    profile_sel, profile_next;
    logic             profile_req;
    logic             profile_ack = 1'b0;

    always #5 up_clk = ~up_clk;

    up_tpl_profile_regs #(
        .NUM_PROFILES(NPROF), .SEL_W(SW), .DEFAULT_PROFILE(0), .TIMEOUT_CYCLES(TOC)
    ) dut (
        .up_clk(up_clk), .up_rstn(up_rstn),
        .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
        .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack),
        .profile_desc(profile_desc), .profile_sel(profile_sel), .profile_next(profile_next),
        .profile_req(profile_req), .profile_ack(profile_ack)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: descriptor fields per profile and transaction-level switch state
    logic [7:0] d_np[NPROF], d_n[NPROF], d_f[NPROF], d_s[NPROF], d_l[NPROF], d_m[NPROF];
    int m_sel, m_next, m_cntrl;
    bit m_busy, m_req, m_inv, m_col, m_to;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge up_clk);
        #1;
    endtask

    function automatic bit in_rng(input logic [13:0] a);
        return (a >= 14'h080) && (a <= 14'h0FF);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [13:0] a);
        int ai, p, k;
        ai = int'(a);
        if (!in_rng(a)) return 32'h0;
        if (ai == 'h80) return 32'(m_cntrl);
        if (ai == 'h81)
            return 32'(NPROF - 1) + 32'(m_sel * 256) + 32'(m_busy) * 32'h10000 +
                   32'(m_inv) * 32'h20000 + 32'(m_col) * 32'h40000 + 32'(m_to) * 32'h80000;
        if (ai >= 'h90 && ai < 'h90 + 4 * NPROF) begin
            p = (ai - 'h90) / 4;
            k = (ai - 'h90) % 4;
            if (k == 0) return {d_f[p], d_s[p], d_l[p], d_m[p]};
            if (k == 1) return {16'h0, d_np[p], d_n[p]};
        end
        return 32'h0;
    endfunction

    task automatic model_reset();
        m_sel = 0; m_next = 0; m_cntrl = 0;
        m_busy = 0; m_req = 0; m_inv = 0; m_col = 0; m_to = 0;
    endtask

    task automatic model_write(input logic [13:0] a, input logic [31:0] d);
        int v;
        if (!in_rng(a)) return;
        if (a == 14'h080) begin
            v = int'(d[SW-1:0]);
            if (v >= NPROF) m_inv = 1;
            else if (m_busy) m_col = 1;
            else begin
                m_cntrl = v;
                if (v != m_sel) begin
                    m_next = v; m_busy = 1; m_req = 1;
                end
            end
        end else if (a == 14'h081) begin
            if (d[17]) m_inv = 0;
            if (d[18]) m_col = 0;
            if (d[19]) m_to = 0;
        end
    endtask

    task automatic bus_wr(input logic [13:0] a, input logic [31:0] d);
        up_waddr = a; up_wdata = d; up_wreq = 1'b1;
        tick();
        up_wreq = 1'b0;
        chk($sformatf("wack@%03h", a), 32'(up_wack), 32'(in_rng(a)));
        model_write(a, d);
        chk("req_after_wr", 32'(profile_req), 32'(m_req));
        chk("next_after_wr", 32'(profile_next), 32'(m_next));
    endtask

    task automatic bus_rd(input logic [13:0] a);
        logic [31:0] e;
        e = exp_rd(a);
        up_raddr = a; up_rreq = 1'b1;
        tick();
        up_rreq = 1'b0;
        chk($sformatf("rack@%03h", a), 32'(up_rack), 32'(in_rng(a)));
        chk($sformatf("rdata@%03h", a), up_rdata, e);
    endtask

    task automatic handshake(input int dly, input int hold);
        for (int i = 0; i < dly; i++) begin
            chk("req_wait", 32'(profile_req), 32'd1);
            tick();
        end
        chk("req_before_ack", 32'(profile_req), 32'd1);
        profile_ack = 1'b1;
        tick();
        m_sel = m_next; m_req = 0;
        chk("sel_after_ack", 32'(profile_sel), 32'(m_sel));
        chk("req_drop", 32'(profile_req), 32'd0);
        for (int i = 0; i < hold; i++) bus_rd(14'h081);
        profile_ack = 1'b0;
        tick();
        m_busy = 0;
        bus_rd(14'h081);
    endtask

    task automatic do_reset();
        up_wreq = 1'b0; up_rreq = 1'b0; profile_ack = 1'b0;
        up_rstn = 1'b0;
        #12;
        model_reset();
        chk("rst_wack", 32'(up_wack), 32'd0);
        chk("rst_rack", 32'(up_rack), 32'd0);
        chk("rst_rdata", up_rdata, 32'd0);
        chk("rst_sel", 32'(profile_sel), 32'd0);
        chk("rst_next", 32'(profile_next), 32'd0);
        chk("rst_req", 32'(profile_req), 32'd0);
        @(negedge up_clk);
        up_rstn = 1'b1;
        tick();
    endtask

    initial begin
        logic [13:0] a;
        int op, v;

        for (int p = 0; p < NPROF; p++) begin
            d_np[p] = 8'($urandom); d_n[p] = 8'($urandom); d_f[p] = 8'($urandom);
            d_s[p]  = 8'($urandom); d_l[p] = 8'($urandom); d_m[p] = 8'($urandom);
        end
        d_np[2] = 8'd16; d_n[2] = 8'd16; d_f[2] = 8'd4; d_s[2] = 8'd1; d_l[2] = 8'd2; d_m[2] = 8'd8;
        for (int p = 0; p < NPROF; p++)
            profile_desc[48*p +: 48] = {d_np[p], d_n[p], d_f[p], d_s[p], d_l[p], d_m[p]};

        do_reset();
        bus_rd(14'h081);
        chk("status_reset_const", up_rdata, 32'h00000003);

        // Descriptor decode for profile 2 and a beyond-range profile slot
        bus_rd(14'h098);
        chk("desc1_p2_const", up_rdata, 32'h04010208);
        bus_rd(14'h099);
        chk("desc2_p2_const", up_rdata, 32'h00001010);
        bus_rd(14'h0A0);
        bus_rd(14'h09A);
        bus_rd(14'h0FF);

        // Out-of-range accesses: no ack, zero data, no state change
        bus_rd(14'h07F);
        bus_rd(14'h100);
        bus_wr(14'h100, 32'h2);
        bus_rd(14'h080);

        // Switch to 2 with ack 5 cycles after req rises
        bus_wr(14'h080, 32'h2);
        handshake(5, 2);
        bus_rd(14'h080);

        // Invalid select then W1C clear
        bus_wr(14'h080, 32'h5);
        bus_rd(14'h081);
        bus_wr(14'h081, 32'h0002_0000);
        bus_rd(14'h081);

        // Collision during a pending switch to 3
        bus_wr(14'h080, 32'h3);
        bus_wr(14'h080, 32'h1);
        handshake(2, 1);
        bus_rd(14'h080);
        bus_wr(14'h081, 32'h0004_0000);
        bus_rd(14'h081);

        // Selecting the already-active profile: acked, no handshake
        bus_wr(14'h080, 32'h3);
        bus_rd(14'h081);

        // Ack held high while idle is ignored
        profile_ack = 1'b1;
        repeat (3) tick();
        chk("idle_ack_req", 32'(profile_req), 32'd0);
        chk("idle_ack_sel", 32'(profile_sel), 32'(m_sel));
        bus_rd(14'h081);
        profile_ack = 1'b0;
        tick();

        // Concurrent write and read in one cycle
        up_waddr = 14'h080; up_wdata = 32'(m_sel); up_wreq = 1'b1;
        up_raddr = 14'h09D; up_rreq = 1'b1;
        tick();
        up_wreq = 1'b0; up_rreq = 1'b0;
        chk("dual_wack", 32'(up_wack), 32'd1);
        chk("dual_rack", 32'(up_rack), 32'd1);
        chk("dual_rdata", up_rdata, exp_rd(14'h09D));

`ifdef JESD_TPL_SWITCH_TIMEOUT_EN
        bus_wr(14'h080, 32'h1);
        for (int i = 0; i < TOC; i++) begin
            chk("to_req_high", 32'(profile_req), 32'd1);
            tick();
        end
        chk("to_req_drop", 32'(profile_req), 32'd0);
        chk("to_sel_kept", 32'(profile_sel), 32'(m_sel));
        m_req = 0; m_to = 1; m_next = m_sel; m_cntrl = m_sel;
        chk("to_next_revert", 32'(profile_next), 32'(m_next));
        tick();
        m_busy = 0;
        bus_rd(14'h081);
        bus_rd(14'h080);
        bus_wr(14'h081, 32'h0008_0000);
        bus_rd(14'h081);
`else
        bus_wr(14'h080, 32'h1);
        repeat (3 * TOC) tick();
        chk("nto_req_held", 32'(profile_req), 32'd1);
        bus_rd(14'h081);
        handshake(0, 0);
`endif

        // Randomized traffic against the model
        for (int it = 0; it < 60; it++) begin
            op = int'($urandom_range(0, 3));
            if (op == 0) begin
                a = 14'h080 + 14'($urandom_range(0, 127));
                bus_rd(a);
            end else if (op == 1) begin
                a = 14'($urandom);
                bus_rd(a);
            end else if (op == 2) begin
                v = int'($urandom_range(0, 7));
                bus_wr(14'h080, 32'(v));
                if (m_busy) handshake(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
            end else begin
                bus_wr(14'h081, $urandom);
            end
        end

        // Reset in the middle of a switch
        v = (m_sel + 1) % NPROF;
        bus_wr(14'h080, 32'(v));
        #2;
        up_rstn = 1'b0;
        #1;
        chk("midrst_req", 32'(profile_req), 32'd0);
        chk("midrst_sel", 32'(profile_sel), 32'd0);
        model_reset();
        @(negedge up_clk);
        up_rstn = 1'b1;
        tick();
        bus_rd(14'h081);
        bus_rd(14'h080);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
